// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC sequencer responder.
// Optional status block is enabled by ADC_SEQ_STATUS_EN (see adc_seq_csr).
package adc_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_CONV,
      ST_EMIT
   } state_e;

   localparam logic       CMD_ADDR    = 1'b0;
   localparam logic       STAT_ADDR   = 1'b1;
   localparam logic [2:0] MODE_CONT   = 3'd0;
   localparam logic [2:0] MODE_SINGLE = 3'd1;
   localparam logic [4:0] TSD_CH      = 5'd17;

endpackage

// File: rtl/adc_seq_csr.sv
// CMD/STATUS register file with registered readdata.
// Status counters exist only when ADC_SEQ_STATUS_EN is defined.
module adc_seq_csr
   import adc_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_address,
   input  logic        csr_write,
   input  logic [31:0] csr_writedata,
   input  logic        csr_read,
   output logic [31:0] csr_readdata,
   input  logic        clr_run_i,
`ifdef ADC_SEQ_STATUS_EN
   input  logic        beat_i,
   input  logic        busy_i,
`endif
   output logic        run_o,
   output logic [2:0]  mode_o
);

   logic        run_q, run_d;
   logic [2:0]  mode_q, mode_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] stat_rd;
   logic        cmd_wr;
   logic        unused_wdata;

   assign cmd_wr       = csr_write && (csr_address == CMD_ADDR);
   assign unused_wdata = ^csr_writedata[31:4];

   // A CMD write beats the end-of-sequence run clear in the same cycle.
   always_comb begin
      run_d  = run_q;
      mode_d = mode_q;
      if (cmd_wr) begin
         run_d  = csr_writedata[0];
         mode_d = csr_writedata[3:1];
      end else if (clr_run_i) begin
         run_d = 1'b0;
      end
   end

`ifdef ADC_SEQ_STATUS_EN
   logic [15:0] cnt_q, cnt_d;
   logic        ovr_q, ovr_d;

   always_comb begin
      cnt_d = cnt_q;
      ovr_d = ovr_q;
      if (csr_write && (csr_address == STAT_ADDR)) begin
         cnt_d = '0;
         ovr_d = 1'b0;
      end else begin
         if (beat_i) cnt_d = cnt_q + 16'd1;
         if (cmd_wr && csr_writedata[0] && busy_i) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovr_q <= ovr_d;
      end
   end

   assign stat_rd = {15'b0, ovr_q, cnt_q};
`else
   assign stat_rd = '0;
`endif

   always_comb begin
      rdata_d = rdata_q;
      if (csr_read) begin
         rdata_d = (csr_address == CMD_ADDR) ? {28'b0, mode_q, run_q} : stat_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         mode_q  <= '0;
         rdata_q <= '0;
      end else begin
         run_q   <= run_d;
         mode_q  <= mode_d;
         rdata_q <= rdata_d;
      end
   end

   assign csr_readdata = rdata_q;
   assign run_o        = run_q;
   assign mode_o       = mode_q;

endmodule

// File: rtl/adc_seq_responder.sv
// Cycle-accurate stand-in for the vendor ADC sequencer: CSR, sample fetch, response stream.
// Define ADC_SEQ_STATUS_EN to build the STATUS counters at CSR address 1.
module adc_seq_responder
   import adc_seq_pkg::*;
#(
   parameter int unsigned              NUM_SLOTS   = 2,
   parameter logic [5*NUM_SLOTS-1:0]   SLOT_CH     = {5'd1, 5'd17},
   parameter int unsigned              CONV_CYCLES = 4,
   parameter int unsigned              DATA_W      = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              csr_address,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   input  logic              csr_read,
   output logic [31:0]       csr_readdata,
   output logic              smp_req,
   output logic [4:0]        smp_channel,
   input  logic              smp_ack,
   input  logic [DATA_W-1:0] smp_data,
   output logic              response_valid,
   output logic [4:0]        response_channel,
   output logic [DATA_W-1:0] response_data,
   output logic              response_startofpacket,
   output logic              response_endofpacket
);

   localparam int unsigned CNT_W       = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES - 1) : 1;
   localparam int unsigned CONV_LAST_I = (CONV_CYCLES > 1) ? CONV_CYCLES - 2 : 0;
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_LAST_I);
   localparam logic [3:0]       LAST_SLOT = 4'(NUM_SLOTS - 1);

   state_e            state_q, state_d;
   logic [3:0]        slot_q, slot_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [2:0]        mode_lat_q, mode_lat_d;
   logic              clr_run;
   logic              run;
   logic [2:0]        mode;
   logic [4:0]        slot_ch;

   adc_seq_csr u_csr (
      .clk           (clk),
      .rst_n         (rst_n),
      .csr_address   (csr_address),
      .csr_write     (csr_write),
      .csr_writedata (csr_writedata),
      .csr_read      (csr_read),
      .csr_readdata  (csr_readdata),
      .clr_run_i     (clr_run),
`ifdef ADC_SEQ_STATUS_EN
      .beat_i        (response_valid),
      .busy_i        (state_q != ST_IDLE),
`endif
      .run_o         (run),
      .mode_o        (mode)
   );

   assign slot_ch = SLOT_CH[5*slot_q +: 5];

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      mode_lat_d = mode_lat_q;
      clr_run    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (run) begin
               mode_lat_d = mode;
               slot_d     = '0;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            // CONV_CYCLES=1 skips CONV so the beat still lands one cycle after the ack
            if (smp_ack) begin
               data_d  = smp_data;
               cnt_d   = '0;
               state_d = (CONV_CYCLES > 1) ? ST_CONV : ST_EMIT;
            end
         end
         ST_CONV: begin
            if (cnt_q == CONV_LAST) state_d = ST_EMIT;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         ST_EMIT: begin
            if (slot_q != LAST_SLOT) begin
               slot_d  = slot_q + 4'd1;
               state_d = ST_REQ;
            end else if (mode_lat_q != MODE_CONT) begin
               clr_run = 1'b1;
               state_d = ST_IDLE;
            end else if (run) begin
               slot_d     = '0;
               mode_lat_d = mode;
               state_d    = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         slot_q     <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         mode_lat_q <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         mode_lat_q <= mode_lat_d;
      end
   end

   assign smp_req                = (state_q == ST_REQ);
   assign smp_channel            = smp_req ? slot_ch : '0;
   assign response_valid         = (state_q == ST_EMIT);
   assign response_channel       = response_valid ? slot_ch : '0;
   assign response_data          = response_valid ? data_q : '0;
   assign response_startofpacket = response_valid && (slot_q == '0);
   assign response_endofpacket   = response_valid && (slot_q == LAST_SLOT);

endmodule

// File: tb/tb_adc_seq_responder.sv
// Scoreboard bench: source model pushes expected beats at ack time, monitors pop and compare.
module tb_adc_seq_responder;
   import adc_seq_pkg::*;

   localparam int unsigned NS = 2;
   localparam int unsigned CC = 4;
   localparam int unsigned DW = 12;
   // slot 0 occupies the LSBs
   localparam logic [9:0] SLOT_CH_TB = {5'd1, TSD_CH};
   localparam logic [4:0] CH_B = 5'd9;

   typedef struct {
      logic [4:0]    ch;
      logic [DW-1:0] d;
      logic          sop;
      logic          eop;
      int unsigned   cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          csr_address = 1'b0;
   logic          csr_write = 1'b0;
   logic [31:0]   csr_writedata = '0;
   logic          csr_read = 1'b0;
   logic [31:0]   csr_readdata;
   logic          smp_req, smp_ack = 1'b0;
   logic [4:0]    smp_channel;
   logic [DW-1:0] smp_data = '0;
   logic          response_valid, response_startofpacket, response_endofpacket;
   logic [4:0]    response_channel;
   logic [DW-1:0] response_data;

   logic          b_req, b_ack = 1'b0;
   logic [4:0]    b_ch, b_rch;
   logic [DW-1:0] b_data = '0, b_rdata;
   logic          b_valid, b_sop, b_eop;
   logic [31:0]   b_readdata;

   int unsigned   cyc = 0;
   int unsigned   checks = 0;
   int unsigned   failures = 0;
   int unsigned   beats = 0;
   int unsigned   beats2 = 0;
   int unsigned   ack_idx = 0;
   int unsigned   stat_cnt = 0;
   logic          ovr_m = 1'b0;
   int            src_delay = -1;
   bit            spur_en = 1'b0;
   logic          rd_seen = 1'b0;

   exp_t          exp_q[$];
   exp_t          exp2_q[$];
   logic [DW-1:0] force_d[$];
   logic [31:0]   rd_q[$];

   adc_seq_responder #(.NUM_SLOTS(NS), .SLOT_CH(SLOT_CH_TB), .CONV_CYCLES(CC), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .csr_address(csr_address), .csr_write(csr_write),
      .csr_writedata(csr_writedata), .csr_read(csr_read), .csr_readdata(csr_readdata),
      .smp_req(smp_req), .smp_channel(smp_channel), .smp_ack(smp_ack), .smp_data(smp_data),
      .response_valid(response_valid), .response_channel(response_channel),
      .response_data(response_data), .response_startofpacket(response_startofpacket),
      .response_endofpacket(response_endofpacket)
   );

   adc_seq_responder #(.NUM_SLOTS(1), .SLOT_CH(CH_B), .CONV_CYCLES(1), .DATA_W(DW)) dut_b (
      .clk(clk), .rst_n(rst_n), .csr_address(csr_address), .csr_write(csr_write),
      .csr_writedata(csr_writedata), .csr_read(csr_read), .csr_readdata(b_readdata),
      .smp_req(b_req), .smp_channel(b_ch), .smp_ack(b_ack), .smp_data(b_data),
      .response_valid(b_valid), .response_channel(b_rch), .response_data(b_rdata),
      .response_startofpacket(b_sop), .response_endofpacket(b_eop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rd_seen <= csr_read && rst_n;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic logic [4:0] slot_ch(input int unsigned s);
      logic [9:0] tbl;
      tbl = SLOT_CH_TB;
      return tbl[5*s +: 5];
   endfunction

   function automatic logic [31:0] stat_exp();
`ifdef ADC_SEQ_STATUS_EN
      logic [31:0] c;
      c = stat_cnt;
      return {15'b0, ovr_m, c[15:0]};
`else
      return 32'h0;
`endif
   endfunction

   // Sample source for the 2-slot DUT: random or forced latency and data.
   int  wait_cnt = 0;
   bit  req_seen = 1'b0;
   always @(negedge clk) begin : src
      exp_t          e;
      logic [DW-1:0] dv;
      int unsigned   s;
      smp_ack = 1'b0;
      if (!rst_n) begin
         req_seen = 1'b0;
      end else if (smp_req) begin
         if (!req_seen) begin
            req_seen = 1'b1;
            wait_cnt = (src_delay >= 0) ? src_delay : int'($urandom_range(0, 3));
         end
         if (wait_cnt == 0) begin
            if (force_d.size() > 0) dv = force_d.pop_front();
            else                    dv = DW'($urandom);
            s = ack_idx % NS;
            chk("smp_channel", 32'(smp_channel), 32'(slot_ch(s)));
            e.ch = slot_ch(s); e.d = dv; e.sop = (s == 0); e.eop = (s == NS - 1);
            e.cyc = cyc + CC;
            exp_q.push_back(e);
            ack_idx++;
            smp_ack  = 1'b1;
            smp_data = dv;
            req_seen = 1'b0;
         end else begin
            wait_cnt--;
         end
      end else if (spur_en && ($urandom_range(0, 3) == 0)) begin
         smp_ack  = 1'b1;
         smp_data = DW'($urandom);
      end
   end

   // Source for the 1-slot DUT: acks immediately.
   always @(negedge clk) begin : src_b
      exp_t          e;
      logic [DW-1:0] dv;
      b_ack = 1'b0;
      if (rst_n && b_req) begin
         dv = DW'($urandom);
         e.ch = CH_B; e.d = dv; e.sop = 1'b1; e.eop = 1'b1; e.cyc = cyc + 1;
         exp2_q.push_back(e);
         b_ack  = 1'b1;
         b_data = dv;
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         if (response_valid) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL beat_unexpected: actual ch=%0d data=%h required no beat (cycle %0d)",
                        response_channel, response_data, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("beat_ch", 32'(response_channel), 32'(e.ch));
               chk("beat_data", 32'(response_data), 32'(e.d));
               chk("beat_sop", 32'(response_startofpacket), 32'(e.sop));
               chk("beat_eop", 32'(response_endofpacket), 32'(e.eop));
               chk("beat_cycle", cyc, e.cyc);
            end
            beats++;
            stat_cnt++;
         end else begin
            chk("idle_outputs", 32'({response_channel, response_data,
                 response_startofpacket, response_endofpacket}), 32'h0);
         end
         if (b_valid) begin
            if (exp2_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL beat1_unexpected: actual data=%h required no beat (cycle %0d)", b_rdata, cyc);
            end else begin
               e = exp2_q.pop_front();
               chk("beat1_ch", 32'(b_rch), 32'(e.ch));
               chk("beat1_data", 32'(b_rdata), 32'(e.d));
               chk("beat1_sop_eop", 32'({b_sop, b_eop}), 32'({e.sop, e.eop}));
               chk("beat1_cycle", cyc, e.cyc);
            end
            beats2++;
         end
      end
      if (rd_seen) begin
         if (rd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL read_unexpected: actual=%h required no read", csr_readdata);
         end else begin
            chk("readdata", csr_readdata, rd_q.pop_front());
         end
      end
   end

   task automatic wr(input logic a, input logic [31:0] d);
      @(negedge clk);
      csr_address = a; csr_writedata = d; csr_write = 1'b1;
      @(negedge clk);
      csr_write = 1'b0;
   endtask

   task automatic rd(input logic a, input logic [31:0] req);
      rd_q.push_back(req);
      @(negedge clk);
      csr_address = a; csr_read = 1'b1;
      @(negedge clk);
      csr_read = 1'b0;
   endtask

   task automatic rw(input logic [31:0] d, input logic [31:0] req);
      rd_q.push_back(req);
      @(negedge clk);
      csr_address = CMD_ADDR; csr_writedata = d; csr_write = 1'b1; csr_read = 1'b1;
      @(negedge clk);
      csr_write = 1'b0; csr_read = 1'b0;
   endtask

   task automatic wait_beats(input int unsigned target, input string name);
      int unsigned n;
      n = 0;
      while (beats < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (16) @(negedge clk);
      chk(name, beats, target);
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, 32'({smp_req, smp_channel, response_valid, response_channel, response_data,
                     response_startofpacket, response_endofpacket}), 32'h0);
      chk({name, "_rdata"}, csr_readdata, 32'h0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned n, base, base_ack, eop_cyc;
      bit          found;
      logic [2:0]  m;

      repeat (3) @(negedge clk);
      #1 chk_outs_zero("reset_outs");
      @(negedge clk);
      rst_n = 1'b1;
      rd(CMD_ADDR, 32'h0);
      rd(STAT_ADDR, 32'h0);

      // Single-cycle run with fixed latency/data; read-with-write returns old value.
      src_delay = 2;
      force_d.push_back(12'hA5A);
      force_d.push_back(12'h7FF);
      base = beats;
      rw({28'b0, MODE_SINGLE, 1'b1}, 32'h0);
      wait_beats(base + 2, "t1_beats");
      rd(CMD_ADDR, 32'h2);

      // CMD run=1 on the exact EOP cycle of a single-cycle run restarts.
      src_delay = -1;
      spur_en   = 1'b1;
      base = beats;
      wr(CMD_ADDR, 32'h3);
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         if (response_valid && response_endofpacket) found = 1'b1;
      end
      chk("t2_eop_seen", 32'(found), 32'h1);
      csr_address = CMD_ADDR; csr_writedata = 32'h3; csr_write = 1'b1;
      eop_cyc = cyc;
      ovr_m = 1'b1;
      @(negedge clk);
      csr_write = 1'b0;
      n = 0;
      while (!smp_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t2_restart_gap", 32'((cyc - eop_cyc) <= 2), 32'h1);
      wait_beats(base + 4, "t2_beats");
      rd(CMD_ADDR, 32'h2);
      rd(STAT_ADDR, stat_exp());

      // Continuous for 3 sequences, busy rewrite, then stop mid slot 0.
      wr(STAT_ADDR, 32'hFFFF_FFFF);
      stat_cnt = 0;
      ovr_m = 1'b0;
      rd(STAT_ADDR, stat_exp());
      base = beats;
      wr(CMD_ADDR, 32'h1);
      n = 0;
      while (beats < base + 6 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("t3_three_seq", 32'(beats >= base + 6), 32'h1);
      n = 0;
      while (!smp_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      wr(CMD_ADDR, 32'h1);
      ovr_m = 1'b1;
      rd(STAT_ADDR, stat_exp());
      wr(CMD_ADDR, 32'h0);
      wait_beats(base + 8, "t3_beats");
      rd(CMD_ADDR, 32'h0);
      rd(STAT_ADDR, stat_exp());
      wr(STAT_ADDR, 32'h0);
      stat_cnt = 0;
      ovr_m = 1'b0;
      rd(STAT_ADDR, stat_exp());

      // Random single-cycle modes 1..7.
      for (int i = 0; i < 4; i++) begin
         m = 3'($urandom_range(1, 7));
         base = beats;
         wr(CMD_ADDR, {28'b0, m, 1'b1});
         wait_beats(base + 2, "t4_beats");
         rd(CMD_ADDR, {28'b0, m, 1'b0});
      end

      // Mode change mid-sequence only takes effect at the next sequence start.
      base = beats;
      wr(CMD_ADDR, 32'h1);
      n = 0;
      while (beats < base + 1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      wr(CMD_ADDR, {28'b0, MODE_SINGLE, 1'b1});
      ovr_m = 1'b1;
      wait_beats(base + 4, "t5_beats");
      rd(CMD_ADDR, 32'h2);
      rd(STAT_ADDR, stat_exp());

      // Asynchronous reset during CONV of slot 1.
      base_ack = ack_idx;
      wr(CMD_ADDR, 32'h1);
      n = 0;
      while (ack_idx < base_ack + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_outs_zero("abort_outs");
      repeat (3) @(negedge clk);
      exp_q.delete();
      exp2_q.delete();
      ack_idx  = 0;
      stat_cnt = 0;
      ovr_m    = 1'b0;
      base = beats;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("abort_no_beats", beats, base);
      rd(CMD_ADDR, 32'h0);
      rd(STAT_ADDR, stat_exp());

      repeat (4) @(negedge clk);
      chk("one_slot_beats_seen", 32'(beats2 > 0), 32'h1);
      chk("exp_q_drained", exp_q.size(), 32'h0);
      chk("exp1_q_drained", exp2_q.size(), 32'h0);
      chk("rd_q_drained", rd_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
